// File: rtl/reg_arb_pkg.sv
// Shared types and widths for the two-port register-bus arbiter.
package reg_arb_pkg;

  localparam int unsigned ARB_ADDR_W = 8;
  localparam int unsigned ARB_DATA_W = 8;
  localparam int unsigned STAT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    arb_op_t               op;
  } arb_req_t;

endpackage

// File: rtl/reg_arb_slot.sv
// One-deep request holding slot: captures a strobe, flags drops into a full slot,
// and lets a new strobe win over a same-cycle grant clear.
module reg_arb_slot
  import reg_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ARB_ADDR_W-1:0] addr,
  input  logic [ARB_DATA_W-1:0] wdata,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr,
  output arb_req_t              req,
  output logic                  busy,
  output logic                  ovf
);

  arb_req_t req_q, req_d;
  logic     busy_q, busy_d;
  logic     ovf_q, ovf_d;
  logic     strobe;

  assign strobe = wr | rd;

  always_comb begin
    req_d  = req_q;
    busy_d = busy_q;
    ovf_d  = ovf_q;
    if (clr) begin
      busy_d = 1'b0;
    end
    if (strobe) begin
      // Only a slot that stays full this cycle drops the strobe.
      if (busy_q && !clr) begin
        ovf_d = 1'b1;
      end else begin
        busy_d      = 1'b1;
        req_d.addr  = addr;
        req_d.wdata = wdata;
        req_d.op    = wr ? OP_WR : OP_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= '0;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign req  = req_q;
  assign busy = busy_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing the register-file port between I2C (port 0) and SPI (port 1).
// Optional grant/conflict counters are built when REG_ARB_STATS_EN is defined.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_wr,
  input  logic              p0_rd,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_busy,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_wr,
  input  logic              p1_rd,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_busy,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wr,
  output logic              m_rd,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [1:0]        ovf
`ifdef REG_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  arb_req_t   req0, req1, win_req;
  logic       busy0, busy1, ovf0, ovf1;
  logic [1:0] clr;
  logic       both_full, any_full, win, grant;

  reg_arb_slot u_slot0 (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (ARB_ADDR_W'(p0_addr)),
    .wdata (ARB_DATA_W'(p0_wdata)),
    .wr    (p0_wr),
    .rd    (p0_rd),
    .clr   (clr[0]),
    .req   (req0),
    .busy  (busy0),
    .ovf   (ovf0)
  );

  reg_arb_slot u_slot1 (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (ARB_ADDR_W'(p1_addr)),
    .wdata (ARB_DATA_W'(p1_wdata)),
    .wr    (p1_wr),
    .rd    (p1_rd),
    .clr   (clr[1]),
    .req   (req1),
    .busy  (busy1),
    .ovf   (ovf1)
  );

  arb_state_t        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              gnt_q, gnt_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_wr_q, m_wr_d;
  logic              m_rd_q, m_rd_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Round-robin pick: a lone request always wins, a tie goes to the other port.
  assign both_full = busy0 & busy1;
  assign any_full  = busy0 | busy1;
  assign win       = both_full ? ~last_grant_q : busy1;
  assign win_req   = win ? req1 : req0;
  assign grant     = (state_q == IDLE) && any_full;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wr_d       = 1'b0;
    m_rd_d       = 1'b0;
    ack_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    clr          = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant) begin
          clr[win]     = 1'b1;
          gnt_d        = win;
          last_grant_d = win;
          m_addr_d     = ADDR_W'(win_req.addr);
          m_wdata_d    = DATA_W'(win_req.wdata);
          if (win_req.op == OP_WR) begin
            m_wr_d = 1'b1;
          end else begin
            m_rd_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_wr_q) begin
          ack_d[gnt_q] = 1'b1;
          state_d      = IDLE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (gnt_q) begin
          rdata1_d = m_rdata;
        end else begin
          rdata0_d = m_rdata;
        end
        ack_d[gnt_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wr_q       <= 1'b0;
      m_rd_q       <= 1'b0;
      ack_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wr_q       <= m_wr_d;
      m_rd_q       <= m_rd_d;
      ack_q        <= ack_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;
  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_busy  = busy0;
  assign p1_busy  = busy1;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_wr     = m_wr_q;
  assign m_rd     = m_rd_q;
  assign ovf      = {ovf1, ovf0};

`ifdef REG_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0_q, stat_grant0_d;
  logic [STAT_W-1:0] stat_grant1_q, stat_grant1_d;
  logic [STAT_W-1:0] stat_conflict_q, stat_conflict_d;

  // Saturating usage counters.
  always_comb begin
    stat_grant0_d   = stat_grant0_q;
    stat_grant1_d   = stat_grant1_q;
    stat_conflict_d = stat_conflict_q;
    if (grant) begin
      if (!win && (stat_grant0_q != '1)) begin
        stat_grant0_d = stat_grant0_q + STAT_W'(1);
      end
      if (win && (stat_grant1_q != '1)) begin
        stat_grant1_d = stat_grant1_q + STAT_W'(1);
      end
      if (both_full && (stat_conflict_q != '1)) begin
        stat_conflict_d = stat_conflict_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_grant0_q   <= stat_grant0_d;
      stat_grant1_q   <= stat_grant1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter with a register-file stand-in and a
// transaction-timer reference model.
module tb_reg_bus_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] p0_addr, p1_addr, m_addr;
  logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, m_wdata, m_rdata;
  logic          p0_wr, p0_rd, p1_wr, p1_rd;
  logic          p0_ack, p1_ack, p0_busy, p1_busy, m_wr, m_rd;
  logic [1:0]    ovf;
`ifdef REG_ARB_STATS_EN
  logic [15:0]   stat_grant0, stat_grant1, stat_conflict;
`endif

  always #5 clk = ~clk;

  reg_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_wr    (p0_wr),
    .p0_rd    (p0_rd),
    .p0_rdata (p0_rdata),
    .p0_ack   (p0_ack),
    .p0_busy  (p0_busy),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_wr    (p1_wr),
    .p1_rd    (p1_rd),
    .p1_rdata (p1_rdata),
    .p1_ack   (p1_ack),
    .p1_busy  (p1_busy),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wr     (m_wr),
    .m_rd     (m_rd),
    .m_rdata  (m_rdata),
    .ovf      (ovf)
`ifdef REG_ARB_STATS_EN
    ,
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict)
`endif
  );

  // Register-file stand-in: read data valid the cycle after m_rd.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (m_rd) m_rdata <= mem[m_addr];
    if (m_wr) mem[m_addr] <= m_wdata;
  end

  int n_chk = 0;
  int n_err = 0;
  int ack_cnt [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mmem [256];
  bit         sf [2];
  bit         swr [2];
  logic [7:0] sa [2];
  logic [7:0] sd [2];
  logic [1:0] e_ovf, e_ack;
  logic [7:0] e_rd [2];
  logic [7:0] e_maddr, e_mwd;
  bit         e_mwr, e_mrd;
  int         last, busy_t, gp;
  bit         gwr;
  logic [7:0] gdata;
  int         e_sg [2];
  int         e_sc;

  task automatic mdl_step();
    bit         stb [2];
    bit         w [2];
    logic [7:0] a [2];
    logic [7:0] d [2];
    bit         clrp [2];
    bit         was;
    int         win;
    stb[0] = p0_wr | p0_rd; w[0] = p0_wr; a[0] = p0_addr; d[0] = p0_wdata;
    stb[1] = p1_wr | p1_rd; w[1] = p1_wr; a[1] = p1_addr; d[1] = p1_wdata;
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        sf[p] = 0; swr[p] = 0; sa[p] = 0; sd[p] = 0; e_rd[p] = 0; e_sg[p] = 0;
      end
      e_ovf = 0; e_ack = 0; e_maddr = 0; e_mwd = 0; e_mwr = 0; e_mrd = 0;
      last = 1; busy_t = 0; gp = 0; gwr = 0; gdata = 0; e_sc = 0;
      return;
    end
    e_ack = 0; e_mwr = 0; e_mrd = 0;
    clrp[0] = 0; clrp[1] = 0;
    if (busy_t == 0) begin
      if (sf[0] || sf[1]) begin
        if (sf[0] && sf[1]) begin
          win = 1 - last;
          if (e_sc < 65535) e_sc++;
        end else begin
          win = sf[1] ? 1 : 0;
        end
        if (e_sg[win] < 65535) e_sg[win]++;
        clrp[win] = 1; last = win; gp = win; gwr = swr[win];
        e_maddr = sa[win]; e_mwd = sd[win];
        if (gwr) begin
          e_mwr = 1; mmem[sa[win]] = sd[win]; busy_t = 1;
        end else begin
          e_mrd = 1; gdata = mmem[sa[win]]; busy_t = 2;
        end
      end
    end else begin
      busy_t--;
      if (busy_t == 0) begin
        e_ack[gp] = 1'b1;
        if (!gwr) e_rd[gp] = gdata;
      end
    end
    for (int p = 0; p < 2; p++) begin
      was = sf[p];
      if (clrp[p]) sf[p] = 0;
      if (stb[p]) begin
        if (was && !clrp[p]) begin
          e_ovf[p] = 1'b1;
        end else begin
          sf[p] = 1; swr[p] = w[p]; sa[p] = a[p]; sd[p] = d[p];
        end
      end
    end
  endtask

  task automatic cmp_all();
    chk("p0_ack", p0_ack, e_ack[0]);
    chk("p1_ack", p1_ack, e_ack[1]);
    chk("p0_busy", p0_busy, sf[0]);
    chk("p1_busy", p1_busy, sf[1]);
    chk("p0_rdata", p0_rdata, e_rd[0]);
    chk("p1_rdata", p1_rdata, e_rd[1]);
    chk("m_addr", m_addr, e_maddr);
    chk("m_wdata", m_wdata, e_mwd);
    chk("m_wr", m_wr, e_mwr);
    chk("m_rd", m_rd, e_mrd);
    chk("ovf", ovf, e_ovf);
`ifdef REG_ARB_STATS_EN
    chk("stat_grant0", stat_grant0, e_sg[0]);
    chk("stat_grant1", stat_grant1, e_sg[1]);
    chk("stat_conflict", stat_conflict, e_sc);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_step();
    #1;
    if (p0_ack === 1'b1) ack_cnt[0]++;
    if (p1_ack === 1'b1) ack_cnt[1]++;
    cmp_all();
  endtask

  task automatic clr_req();
    p0_wr = 0; p0_rd = 0; p1_wr = 0; p1_rd = 0;
  endtask

  task automatic set_req(input int p, input bit wr, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin
      p0_wr = wr; p0_rd = !wr; p0_addr = a; p0_wdata = d;
    end else begin
      p1_wr = wr; p1_rd = !wr; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    clr_req();
    tick();
    tick();
    rst_n = 1;
  endtask

  typedef struct {
    int         port;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         ack_cyc;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];
  int   a0, a1;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i);
      mmem[i] = 8'(i);
    end
    mem[0]  = 8'hA7;
    mmem[0] = 8'hA7;
    m_rdata = 0;
    p0_addr = 0; p0_wdata = 0; p1_addr = 0; p1_wdata = 0;
    clr_req();
    ack_cnt[0] = 0; ack_cnt[1] = 0;

    do_reset();
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p0_busy", p0_busy, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_rd", m_rd, 0);
    chk("rst_ovf", ovf, 0);

    // Single uncontended accesses with fixed expected latency and data.
    tbl[0] = '{0, 0, 8'h00, 8'h00, 4, 8'hA7};
    tbl[1] = '{1, 1, 8'h05, 8'h55, 3, 8'h00};
    tbl[2] = '{0, 0, 8'h05, 8'h00, 4, 8'h55};
    tbl[3] = '{1, 0, 8'h01, 8'h00, 4, 8'h01};
    tbl[4] = '{0, 1, 8'h20, 8'hF0, 3, 8'h00};
    tbl[5] = '{1, 0, 8'h20, 8'h00, 4, 8'hF0};
    for (int v = 0; v < 6; v++) begin
      set_req(tbl[v].port, tbl[v].wr, tbl[v].addr, tbl[v].wdata);
      tick();
      clr_req();
      chk("tbl_busy_c1", (tbl[v].port == 0) ? p0_busy : p1_busy, 1);
      tick();
      chk("tbl_busy_c2", (tbl[v].port == 0) ? p0_busy : p1_busy, 0);
      chk("tbl_m_wr_c2", m_wr, tbl[v].wr);
      chk("tbl_m_rd_c2", m_rd, !tbl[v].wr);
      chk("tbl_m_addr_c2", m_addr, tbl[v].addr);
      for (int c = 3; c <= 6; c++) begin
        tick();
        chk("tbl_ack", (tbl[v].port == 0) ? p0_ack : p1_ack, (c == tbl[v].ack_cyc) ? 1 : 0);
        chk("tbl_other_ack", (tbl[v].port == 0) ? p1_ack : p0_ack, 0);
        if (c == tbl[v].ack_cyc && !tbl[v].wr)
          chk("tbl_rdata", (tbl[v].port == 0) ? p0_rdata : p1_rdata, tbl[v].exp_rdata);
      end
    end

    // Simultaneous writes after reset: port 0 first, port 1 two cycles later.
    do_reset();
    set_req(0, 1, 8'h20, 8'hF0);
    set_req(1, 1, 8'h05, 8'h12);
    tick(); clr_req();
    tick();
    chk("tie_m_addr0", m_addr, 8'h20);
    chk("tie_m_wdata0", m_wdata, 8'hF0);
    tick();
    chk("tie_p0_ack", p0_ack, 1);
    chk("tie_p1_ack_early", p1_ack, 0);
    tick();
    chk("tie_m_addr1", m_addr, 8'h05);
    chk("tie_m_wr1", m_wr, 1);
    tick();
    chk("tie_p1_ack", p1_ack, 1);
    tick();
    chk("tie_mem20", mem[8'h20], 8'hF0);
    set_req(0, 1, 8'h21, 8'hA1);
    set_req(1, 1, 8'h06, 8'hB2);
    tick(); clr_req();
    tick();
    chk("tie2_winner", m_addr, 8'h21);
    repeat (4) tick();

    // Port 1 strobes into its own full slot while port 0 holds the bus.
    do_reset();
    a1 = ack_cnt[1];
    set_req(0, 0, 8'h00, 8'h00);
    tick(); clr_req();
    set_req(1, 1, 8'h07, 8'h33);
    tick(); clr_req();
    chk("ovf_p1_busy", p1_busy, 1);
    tick();
    set_req(1, 1, 8'h08, 8'h44);
    tick(); clr_req();
    chk("ovf_flag", ovf, 2'b10);
    repeat (8) tick();
    chk("ovf_p1_acks", ack_cnt[1] - a1, 1);
    chk("ovf_mem7", mem[8'h07], 8'h33);
    chk("ovf_mem8", mem[8'h08], 8'h08);
    chk("ovf_sticky", ovf, 2'b10);

    // Reset asserted during RDWAIT of a port 0 read.
    do_reset();
    a0 = ack_cnt[0];
    set_req(0, 0, 8'h00, 8'h00);
    tick(); clr_req();
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("rmid_p0_ack", p0_ack, 0);
    chk("rmid_p0_rdata", p0_rdata, 0);
    chk("rmid_p0_busy", p0_busy, 0);
    chk("rmid_m_addr", m_addr, 0);
    chk("rmid_m_wdata", m_wdata, 0);
    chk("rmid_m_rd", m_rd, 0);
    chk("rmid_ovf", ovf, 0);
    repeat (5) tick();
    chk("rmid_no_ack", ack_cnt[0] - a0, 0);
    set_req(0, 0, 8'h01, 8'h00);
    tick(); clr_req();
    repeat (3) tick();
    chk("rmid_read_ack", p0_ack, 1);
    chk("rmid_read_data", p0_rdata, 8'h01);
    tick();

`ifdef REG_ARB_STATS_EN
    do_reset();
    for (int t = 0; t < 3; t++) begin
      set_req(0, 1, 8'(8'h30 + t), 8'(t));
      set_req(1, 1, 8'(8'h40 + t), 8'(t));
      tick(); clr_req();
      repeat (6) tick();
    end
    set_req(0, 0, 8'h00, 8'h00);
    tick(); clr_req();
    repeat (6) tick();
    chk("stat_g0", stat_grant0, 4);
    chk("stat_g1", stat_grant1, 3);
    chk("stat_conf_ge3", (stat_conflict >= 16'd3) ? 1 : 0, 1);
`endif

    // Randomized traffic with occasional resets against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      p0_wr = ($urandom_range(0, 7) == 0);
      p0_rd = ($urandom_range(0, 7) == 0);
      p1_wr = ($urandom_range(0, 7) == 0);
      p1_rd = ($urandom_range(0, 7) == 0);
      p0_addr = 8'($urandom_range(0, 7));
      p1_addr = 8'($urandom_range(0, 7));
      p0_wdata = 8'($urandom);
      p1_wdata = 8'($urandom);
      tick();
    end
    rst_n = 1;
    clr_req();
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
